cart_mapper_mem: RTL and testbench
==================================

Name: cart_mapper_mem

Overview:
- Parametrised cartridge memory: streaming-loaded ROM image, banked CPU window, optional on-cart work RAM, and image-size mirroring.
- Sits between the host loader stream and the console CPU bus, in place of the flat cartridge ROM.
- A loader FSM accepts image bytes with a valid/ready handshake. The CPU sees a fixed low half and a bank-switched high half of its window.

Parameters:
- ROM_AW, 17, ROM address width; capacity 2^ROM_AW bytes.
- CPU_AW, 15, CPU window address width; each half is 2^(CPU_AW-1) bytes.
- DW, 8, data width.
- BANK_W, 4, bank register width.
- RAM_AW, 11, work-RAM address width; 0 = no RAM (RAM_CSB ignored, RAM reads return all-ones).

Ports:
- CLK  in  1  clock
- RESB  in  1  reset; one clock; reset is synchronous and active-low
- INIT_START  in  1  pulse: restart loader at address 0
- INIT_END  in  1  pulse: terminate load early
- INIT_DATA  in  DW  image byte
- INIT_VALID  in  1  byte valid
- INIT_READY  out  1  loader accepts bytes
- INIT_DONE  out  1  image complete, CPU access enabled
- INIT_CNT  out  ROM_AW+1  bytes accepted
- A  in  CPU_AW  CPU address
- DI  in  DW  CPU write data
- DB  out  DW  CPU read data, registered
- CSB  in  1  ROM/mapper select, active-low
- RAM_CSB  in  1  work-RAM select, active-low
- WRB  in  1  write strobe, active-low
- BANK  out  BANK_W  current bank

Behaviour:
- Reset (RESB=0 at posedge):
  - FSM goes to IDLE; INIT_READY=0, INIT_DONE=0, INIT_CNT=0, BANK=0, DB=all-ones, MASK=all-ones.
  - ROM and RAM contents are not cleared.
  - Reset mid-load aborts the load; loaded bytes are retained but INIT_DONE stays 0.
- FSM states IDLE, LOAD, DONE:
  - INIT_START in any state -> LOAD, ptr=0, INIT_CNT=0, INIT_DONE=0, BANK=0.
  - LOAD: INIT_READY=1. A transfer occurs when INIT_VALID and INIT_READY are high at a posedge. It writes mem[ptr] and increments ptr and INIT_CNT.
  - LOAD -> DONE on INIT_END, or on accepting byte index 2^ROM_AW-1. INIT_READY drops the cycle after the final accept.
  - INIT_START takes priority over a same-cycle transfer; that byte is dropped and not counted.
  - INIT_END with a same-cycle transfer: the byte is written and counted, then the FSM enters DONE.
  - INIT_END with INIT_CNT=0: the FSM enters DONE with MASK=0.
  - Entering DONE latches MASK = (smallest power of two >= final INIT_CNT) - 1, masked to ROM_AW bits.
- CPU ROM path (INIT_DONE=1, CSB=0):
  - Read (WRB=1): rom_addr = A[CPU_AW-1] ? {BANK, A[CPU_AW-2:0]} : A[CPU_AW-2:0]. Zero-extend/truncate to ROM_AW, then AND with MASK. DB <= mem[rom_addr] at the next posedge (1-cycle latency).
  - Write (WRB=0) with A[CPU_AW-1]=1: BANK <= DI[BANK_W-1:0]. The new bank applies from the next access.
  - Write to the low half: ignored. ROM is never CPU-writable.
- RAM path (RAM_AW>0, RAM_CSB=0, CSB=1):
  - Read: DB <= ram[A[RAM_AW-1:0]], 1-cycle latency.
  - Write: ram[...] <= DI.
  - RAM is usable regardless of INIT_DONE.
- CSB=0 and RAM_CSB=0 together: ROM path wins; RAM is not accessed.
- Reads with INIT_DONE=0: DB <= all-ones.
- No select, or any write cycle: DB holds its previous value (never X).

Optional Feature:
- Macro: CART_INIT_CSUM_EN.
- Defined: adds output INIT_CSUM [15:0], the running sum mod 2^16 of accepted INIT_DATA. Cleared on reset and INIT_START; frozen in DONE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then INIT_START, stream 0x00..0xFF (256 bytes), INIT_END -> INIT_CNT=256, MASK=0xFF, INIT_DONE=1. CPU read A=0x0005 gives DB=0x05 one cycle later; A=0x0105 gives 0x05 (mirror).
- Load 2^17 bytes with INIT_VALID toggling every other cycle -> auto DONE after the last accept; INIT_READY=0 next cycle; INIT_CNT=0x20000.
- After full load, write DI=0x03 to A=0x4000 -> BANK=3; read A=0x4010 -> mem[0x0C010]. Read A=0x0010 -> mem[0x00010].
- INIT_START asserted with INIT_VALID in the same cycle -> byte dropped, INIT_CNT=0. INIT_END with a transfer -> byte counted; CPU read before DONE -> DB=0xFF.
- RAM write 0x5A at A=0x07FF, RAM_CSB=0 -> read returns 0x5A. Same access with CSB=0 also low -> ROM data returned, RAM unchanged.
- With CART_INIT_CSUM_EN: load bytes 0x01,0x02,0xFF -> INIT_CSUM=0x0102. Reset mid-load -> INIT_CSUM=0, INIT_DONE=0.

Source files
------------

// File: rtl/cart_mapper_mem.sv
// Cartridge memory: stream-loaded ROM image, banked CPU window, optional work RAM, size mirroring.
// Define CART_INIT_CSUM_EN to add the INIT_CSUM running checksum of the loaded image.
module cart_mapper_mem #(
    parameter int ROM_AW = 17,
    parameter int CPU_AW = 15,
    parameter int DW     = 8,
    parameter int BANK_W = 4,
    parameter int RAM_AW = 11
) (
    input  logic              CLK,
    input  logic              RESB,
    input  logic              INIT_START,
    input  logic              INIT_END,
    input  logic [DW-1:0]     INIT_DATA,
    input  logic              INIT_VALID,
    output logic              INIT_READY,
    output logic              INIT_DONE,
    output logic [ROM_AW:0]   INIT_CNT,
    input  logic [CPU_AW-1:0] A,
    input  logic [DW-1:0]     DI,
    output logic [DW-1:0]     DB,
    input  logic              CSB,
    input  logic              RAM_CSB,
    input  logic              WRB,
    output logic [BANK_W-1:0] BANK
`ifdef CART_INIT_CSUM_EN
    ,
    output logic [15:0]       INIT_CSUM
`endif
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] SRC_ONES = 2'd0;
    localparam logic [1:0] SRC_ROM  = 2'd1;
    localparam logic [1:0] SRC_RAM  = 2'd2;
    localparam int HALF_AW = CPU_AW - 1;
    localparam int FULL_AW = BANK_W + HALF_AW;
    localparam logic [ROM_AW:0] CNT_ONE  = 1;
    localparam logic [ROM_AW:0] LAST_CNT = {1'b0, {ROM_AW{1'b1}}};

    logic [1:0]         state_q, state_d;
    logic [ROM_AW:0]    cnt_q, cnt_d;
    logic [ROM_AW-1:0]  mask_q, mask_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [1:0]         src_q, src_d;
    logic [DW-1:0]      rom_rdata_q;
    logic [DW-1:0]      ram_rdata;
    logic               xfer, rom_rd, rom_bank_wr, ram_rd, ram_wr;
    logic [FULL_AW-1:0] cpu_full_addr;
    logic [ROM_AW-1:0]  rom_addr;
    logic [DW-1:0]      rom_mem [2**ROM_AW];

    // Smallest power of two >= n, minus one; an empty image maps everything onto byte 0.
    function automatic logic [ROM_AW-1:0] size_mask(input logic [ROM_AW:0] n);
        logic [ROM_AW:0] v;
        v = (n == '0) ? '0 : n - CNT_ONE;
        for (int i = 1; i <= ROM_AW; i++) v = v | (v >> i);
        return v[ROM_AW-1:0];
    endfunction

    assign xfer        = RESB && (state_q == ST_LOAD) && INIT_VALID && !INIT_START;
    assign rom_rd      = !CSB && WRB;
    assign rom_bank_wr = (state_q == ST_DONE) && !CSB && !WRB && A[CPU_AW-1];
    assign ram_rd      = CSB && !RAM_CSB && WRB;
    assign ram_wr      = CSB && !RAM_CSB && !WRB;

    assign cpu_full_addr = A[CPU_AW-1] ? {bank_q, A[HALF_AW-1:0]}
                                       : {{BANK_W{1'b0}}, A[HALF_AW-1:0]};
    assign rom_addr      = ROM_AW'(cpu_full_addr) & mask_q;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        bank_d  = bank_q;
        src_d   = src_q;
        if (INIT_START) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            bank_d  = '0;
        end else begin
            if (xfer) cnt_d = cnt_q + CNT_ONE;
            if ((state_q == ST_LOAD) && (INIT_END || (xfer && cnt_q == LAST_CNT))) begin
                state_d = ST_DONE;
                mask_d  = size_mask(cnt_d);
            end
            if (rom_bank_wr) bank_d = DI[BANK_W-1:0];
        end
        if (rom_rd)      src_d = (state_q == ST_DONE) ? SRC_ROM : SRC_ONES;
        else if (ram_rd) src_d = SRC_RAM;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESB) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '1;
            bank_q  <= '0;
            src_q   <= SRC_ONES;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            bank_q  <= bank_d;
            src_q   <= src_d;
        end
    end

    // NOTE: memory arrays have no reset; the image survives RESB and only the loader writes it.
    always_ff @(posedge CLK) begin
        if (xfer) rom_mem[cnt_q[ROM_AW-1:0]] <= INIT_DATA;
        if (rom_rd && state_q == ST_DONE) rom_rdata_q <= rom_mem[rom_addr];
    end

    generate
        if (RAM_AW > 0) begin : g_ram
            logic [DW-1:0] ram_mem [2**RAM_AW];
            logic [DW-1:0] ram_rdata_q;
            always_ff @(posedge CLK) begin
                if (ram_wr) ram_mem[A[RAM_AW-1:0]] <= DI;
                if (ram_rd) ram_rdata_q <= ram_mem[A[RAM_AW-1:0]];
            end
            assign ram_rdata = ram_rdata_q;
        end else begin : g_no_ram
            assign ram_rdata = '1;
        end
    endgenerate

    // DB only changes on reads; the source select holds it stable through idle and write cycles.
    always_comb begin
        case (src_q)
            SRC_ROM: DB = rom_rdata_q;
            SRC_RAM: DB = ram_rdata;
            default: DB = '1;
        endcase
    end

    assign INIT_READY = (state_q == ST_LOAD);
    assign INIT_DONE  = (state_q == ST_DONE);
    assign INIT_CNT   = cnt_q;
    assign BANK       = bank_q;

`ifdef CART_INIT_CSUM_EN
    logic [15:0] csum_q;
    always_ff @(posedge CLK) begin
        if (!RESB || INIT_START) csum_q <= '0;
        else if (xfer)           csum_q <= csum_q + 16'(INIT_DATA);
    end
    assign INIT_CSUM = csum_q;
`endif

endmodule

// File: tb/tb_cart_mapper_mem.sv
// Self-checking bench for cart_mapper_mem: directed sequences, a vector table and a randomized
// phase compared against a behavioural model of the cartridge.
module tb_cart_mapper_mem;
    localparam int ROM_AW  = 13;
    localparam int CPU_AW  = 12;
    localparam int DW      = 8;
    localparam int BANK_W  = 4;
    localparam int RAM_AW  = 11;
    localparam int ROM_SZ  = 1 << ROM_AW;
    localparam int HALF_SZ = 1 << (CPU_AW - 1);
    localparam int RAM_SZ  = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              resb, init_start, init_end, init_valid, csb, ram_csb, wrb;
    logic [DW-1:0]     init_data, di, db;
    logic              init_ready, init_done;
    logic [ROM_AW:0]   init_cnt;
    logic [CPU_AW-1:0] a;
    logic [BANK_W-1:0] bank;
`ifdef CART_INIT_CSUM_EN
    logic [15:0]       init_csum;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    byte unsigned ref_rom [ROM_SZ];
    byte unsigned ref_ram [RAM_SZ];
    bit m_loading, m_done;
    int m_cnt, m_mask, m_bank, m_db, m_csum;

    typedef struct {
        logic        csb, ram_csb, wrb;
        logic [11:0] a;
        logic [7:0]  di;
        logic [7:0]  exp_db;
        logic [3:0]  exp_bank;
    } tv_t;
    tv_t tbl [15];

    cart_mapper_mem #(
        .ROM_AW(ROM_AW), .CPU_AW(CPU_AW), .DW(DW), .BANK_W(BANK_W), .RAM_AW(RAM_AW)
    ) dut (
        .CLK(clk), .RESB(resb),
        .INIT_START(init_start), .INIT_END(init_end), .INIT_DATA(init_data),
        .INIT_VALID(init_valid), .INIT_READY(init_ready), .INIT_DONE(init_done),
        .INIT_CNT(init_cnt),
        .A(a), .DI(di), .DB(db), .CSB(csb), .RAM_CSB(ram_csb), .WRB(wrb), .BANK(bank)
`ifdef CART_INIT_CSUM_EN
        , .INIT_CSUM(init_csum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int size_mask_ref(input int n);
        int p = 1;
        while (p < n) p = p * 2;
        return (p - 1) & (ROM_SZ - 1);
    endfunction

    // One clock of the cartridge as described by its rules, using pre-edge state and inputs.
    task automatic model_step();
        int off, full, nbank;
        if (!resb) begin
            m_loading = 0; m_done = 0; m_cnt = 0; m_bank = 0;
            m_db = 'hFF; m_mask = ROM_SZ - 1; m_csum = 0;
            return;
        end
        nbank = m_bank;
        if (!csb) begin
            if (wrb) begin
                if (m_done) begin
                    off  = a % HALF_SZ;
                    full = (a >= HALF_SZ) ? m_bank * HALF_SZ + off : off;
                    m_db = ref_rom[(full % ROM_SZ) & m_mask];
                end else begin
                    m_db = 'hFF;
                end
            end else if (m_done && a >= HALF_SZ) begin
                nbank = di % (1 << BANK_W);
            end
        end else if (!ram_csb) begin
            if (wrb) m_db = ref_ram[a % RAM_SZ];
            else     ref_ram[a % RAM_SZ] = di;
        end
        if (init_start) begin
            m_loading = 1; m_done = 0; m_cnt = 0; nbank = 0; m_csum = 0;
        end else if (m_loading) begin
            if (init_valid) begin
                ref_rom[m_cnt] = init_data;
                m_cnt++;
                m_csum = (m_csum + init_data) % 65536;
            end
            if (init_end || m_cnt == ROM_SZ) begin
                m_loading = 0; m_done = 1; m_mask = size_mask_ref(m_cnt);
            end
        end
        m_bank = nbank;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ready"}, init_ready, m_loading);
        check({tag, "_done"},  init_done,  m_done);
        check({tag, "_cnt"},   init_cnt,   m_cnt);
        check({tag, "_bank"},  bank,       m_bank);
        check({tag, "_db"},    db,         m_db);
`ifdef CART_INIT_CSUM_EN
        check({tag, "_csum"},  init_csum,  m_csum);
`endif
    endtask

    initial begin
        resb = 1'b0; init_start = 1'b0; init_end = 1'b0; init_valid = 1'b0; init_data = '0;
        csb = 1'b1; ram_csb = 1'b1; wrb = 1'b1; a = '0; di = '0;
        tick(); tick();
        check("rst_ready", init_ready, 0);
        check("rst_done",  init_done,  0);
        check("rst_cnt",   init_cnt,   0);
        check("rst_bank",  bank,       0);
        check("rst_db",    db,         32'hFF);
        resb = 1'b1;

        // Fill work RAM with a known pattern; RAM works before any image is loaded
        ram_csb = 1'b0; wrb = 1'b0;
        for (int i = 0; i < RAM_SZ; i++) begin
            a = 12'(i); di = 8'(i * 3 + 17);
            tick();
        end
        wrb = 1'b1; a = 12'h010;
        tick();
        check("ram_before_done", db, 32'h41);
        ram_csb = 1'b1; csb = 1'b0; a = 12'h005;
        tick();
        check("rom_rd_not_done", db, 32'hFF);
        csb = 1'b1;

        // Start with a same-cycle byte: the byte is dropped
        init_start = 1'b1; init_valid = 1'b1; init_data = 8'hAA;
        tick();
        init_start = 1'b0;
        check("start_drop_cnt", init_cnt, 0);
        check("start_ready", init_ready, 1);
        for (int i = 0; i < 256; i++) begin
            init_data = 8'(i); init_end = (i == 255);
            tick();
        end
        init_valid = 1'b0; init_end = 1'b0;
        check("load256_cnt",   init_cnt,   256);
        check("load256_done",  init_done,  1);
        check("load256_ready", init_ready, 0);

        tbl[0]  = '{1'b0, 1'b1, 1'b1, 12'h005, 8'h00, 8'h05, 4'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 12'h105, 8'h00, 8'h05, 4'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 12'h7AB, 8'h00, 8'hAB, 4'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 12'h800, 8'h02, 8'hAB, 4'h2};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'h812, 8'h00, 8'h12, 4'h2};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 12'h010, 8'h07, 8'h12, 4'h2};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 12'h010, 8'h00, 8'h10, 4'h2};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 12'h7FF, 8'h5A, 8'h10, 4'h2};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 12'h7FF, 8'h00, 8'h5A, 4'h2};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 12'h7FF, 8'h00, 8'h5A, 4'h2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 12'h7FF, 8'h00, 8'hFF, 4'h2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 12'h7FF, 8'h11, 8'hFF, 4'h2};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 12'h7FF, 8'h00, 8'h5A, 4'h2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 12'h800, 8'h01, 8'h5A, 4'h1};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 12'h000, 8'h00, 8'h11, 4'h1};
        for (int i = 0; i < 15; i++) begin
            csb = tbl[i].csb; ram_csb = tbl[i].ram_csb; wrb = tbl[i].wrb;
            a = tbl[i].a; di = tbl[i].di;
            tick();
            check($sformatf("tbl%0d_db", i),   db,   tbl[i].exp_db);
            check($sformatf("tbl%0d_bank", i), bank, tbl[i].exp_bank);
        end
        csb = 1'b1; ram_csb = 1'b1; wrb = 1'b1;

        // Full-capacity load, INIT_VALID on every other cycle, auto-completes on the last byte
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int c = 0; c < 4 * ROM_SZ && !m_done; c++) begin
            init_valid = (c % 2 == 1);
            init_data  = 8'((c / 2) ^ ((c / 2) >> 5));
            tick();
            check("full_ready", init_ready, m_loading);
        end
        check("full_done",       init_done,  1);
        check("full_ready_drop", init_ready, 0);
        check("full_cnt",        init_cnt,   32'h2000);
        init_valid = 1'b0;

        csb = 1'b0; wrb = 1'b0; a = 12'h800; di = 8'h03;
        tick();
        check("bank3", bank, 3);
        wrb = 1'b1; a = 12'h810;
        tick();
        check("bank3_rd", db, ref_rom[13'h1810]);
        a = 12'h010;
        tick();
        check("low_rd", db, ref_rom[13'h0010]);
        wrb = 1'b0; a = 12'h800; di = 8'h0D;
        tick();
        check("bank13", bank, 13);
        wrb = 1'b1; a = 12'h810;
        tick();
        check("bank_trunc_rd", db, ref_rom[13'h0810]);
        csb = 1'b1;

        // INIT_END on an empty load: mask 0, every ROM read maps to byte 0
        init_start = 1'b1;
        tick();
        init_start = 1'b0; init_end = 1'b1;
        tick();
        init_end = 1'b0;
        check("empty_done", init_done, 1);
        check("empty_cnt",  init_cnt,  0);
        csb = 1'b0; a = 12'h457;
        tick();
        check("empty_mask_rd", db, 32'h00);
        csb = 1'b1;

        // Partial load, then reset mid-load
        init_start = 1'b1;
        tick();
        init_start = 1'b0; init_valid = 1'b1;
        init_data = 8'h01; tick();
        init_data = 8'h02; tick();
        init_data = 8'hFF; tick();
        init_valid = 1'b0;
        check("part_cnt",   init_cnt,   3);
        check("part_ready", init_ready, 1);
`ifdef CART_INIT_CSUM_EN
        check("part_csum", init_csum, 32'h0102);
`endif
        resb = 1'b0;
        tick();
        resb = 1'b1;
        check("midrst_done",  init_done,  0);
        check("midrst_ready", init_ready, 0);
        check("midrst_cnt",   init_cnt,   0);
`ifdef CART_INIT_CSUM_EN
        check("midrst_csum", init_csum, 0);
`endif
        ram_csb = 1'b0; a = 12'h7FF;
        tick();
        check("midrst_ram_rd", db, 32'h5A);
        ram_csb = 1'b1; csb = 1'b0; a = 12'h000;
        tick();
        check("midrst_rom_rd", db, 32'hFF);
        csb = 1'b1;

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            resb       = ($urandom_range(255) != 0);
            init_start = ($urandom_range(63) == 0);
            init_end   = ($urandom_range(63) == 0);
            init_valid = $urandom_range(1);
            init_data  = 8'($urandom);
            csb        = resb ? 1'($urandom_range(1)) : 1'b1;
            ram_csb    = resb ? 1'($urandom_range(1)) : 1'b1;
            wrb        = $urandom_range(1);
            a          = 12'($urandom);
            di         = 8'($urandom);
            tick();
            check_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
